// File: rtl/spi_arb.sv
// spi_arb: two-port round-robin arbiter and sequencer for one shared 16-bit
// SPI master. It grants one requester at a time, launches its command with a
// one-cycle strobe, and waits for a rising edge of the master's level-type
// done. It then returns the read word with a one-cycle ack to that port. A
// watchdog aborts a transfer whose done never arrives: the port gets ack with
// rdat=FFFF and err pulses alongside the ack.
//
// Ports:
//   clk, rst_n            clock, async active-low reset
//   req0/cmd0/ack0/rdat0  requester port 0 (req level, ack pulse)
//   req1/cmd1/ack1/rdat1  requester port 1
//   spi_wrt/spi_cmd       launch strobe and command to the SPI master
//   spi_done/spi_rd_data  master done level and read word
//   busy                  high while not IDLE
//   err                   pulses with an ack caused by timeout
module spi_arb #(
  parameter int TIMEOUT_CYC = 1023
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0,
  input  logic [15:0] cmd0,
  output logic        ack0,
  output logic [15:0] rdat0,
  input  logic        req1,
  input  logic [15:0] cmd1,
  output logic        ack1,
  output logic [15:0] rdat1,
  output logic        spi_wrt,
  output logic [15:0] spi_cmd,
  input  logic        spi_done,
  input  logic [15:0] spi_rd_data,
  output logic        busy,
  output logic        err
);

  localparam logic [10:0] TMO = 11'(TIMEOUT_CYC);

  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, GAP} state_t;

  state_t      state, state_nxt;
  logic        gnt, gnt_nxt, last_gnt;
  logic        done_q;
  logic [10:0] tcnt;
  logic [10:0] tcnt_inc;
  logic        done_rise;
  logic        grant, finish, timeout;

  // A done level left over from the previous transfer is filtered out by
  // looking only for a 0->1 transition.
  assign done_rise = spi_done & ~done_q;

  // tcnt_inc counts WAIT cycles including the current one, so the abort
  // ack lands TIMEOUT_CYC+1 cycles after the launch cycle.
  assign tcnt_inc  = tcnt + 11'd1;

  always_comb begin
    state_nxt = state;
    gnt_nxt   = gnt;
    grant     = 1'b0;
    finish    = 1'b0;
    timeout   = 1'b0;
    case (state)
      IDLE: begin
        if (req0 | req1) begin
          grant     = 1'b1;
          // On a tie the port that did not win last time gets the grant.
          gnt_nxt   = (req0 & req1) ? ~last_gnt : req1;
          state_nxt = LAUNCH;
        end
      end
      LAUNCH: state_nxt = WAIT;
      WAIT: begin
        // Completion takes priority over a coincident timeout.
        if (done_rise) begin
          finish    = 1'b1;
          state_nxt = GAP;
        end else if (tcnt_inc == TMO) begin
          finish    = 1'b1;
          timeout   = 1'b1;
          state_nxt = GAP;
        end
      end
      GAP: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      gnt      <= 1'b0;
      last_gnt <= 1'b1;
      done_q   <= 1'b0;
      tcnt     <= '0;
      spi_wrt  <= 1'b0;
      spi_cmd  <= '0;
      ack0     <= 1'b0;
      ack1     <= 1'b0;
      rdat0    <= '0;
      rdat1    <= '0;
      busy     <= 1'b0;
      err      <= 1'b0;
    end else begin
      state   <= state_nxt;
      done_q  <= spi_done;
      spi_wrt <= grant;
      busy    <= (state_nxt != IDLE);
      ack0    <= finish & ~gnt;
      ack1    <= finish & gnt;
      err     <= timeout;
      if (grant) begin
        gnt      <= gnt_nxt;
        last_gnt <= gnt_nxt;
        spi_cmd  <= gnt_nxt ? cmd1 : cmd0;
      end
      if (state == LAUNCH)
        tcnt <= '0;
      else if (state == WAIT)
        tcnt <= tcnt_inc;
      if (finish) begin
        if (gnt) rdat1 <= timeout ? 16'hFFFF : spi_rd_data;
        else     rdat0 <= timeout ? 16'hFFFF : spi_rd_data;
      end
    end
  end

endmodule

// File: tb/tb_spi_arb.sv
// Bench for spi_arb: one process drives requesters and a behavioural SPI
// master, and checks acks against a queue of expected transactions.
module tb_spi_arb;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req0 = 1'b0, req1 = 1'b0;
  logic [15:0] cmd0 = '0, cmd1 = '0;
  logic        ack0, ack1;
  logic [15:0] rdat0, rdat1;
  logic        spi_wrt;
  logic [15:0] spi_cmd;
  logic        spi_done = 1'b0;
  logic [15:0] spi_rd_data = '0;
  logic        busy, err;

  spi_arb #(.TIMEOUT_CYC(1023)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .cmd0(cmd0), .ack0(ack0), .rdat0(rdat0),
    .req1(req1), .cmd1(cmd1), .ack1(ack1), .rdat1(rdat1),
    .spi_wrt(spi_wrt), .spi_cmd(spi_cmd),
    .spi_done(spi_done), .spi_rd_data(spi_rd_data),
    .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit          port;
    logic [15:0] cmd;
    logic [15:0] rdat;
    bit          err;
    bit          tmo;
  } exp_t;

  exp_t sb[$];

  int n_chk = 0, n_err = 0;

  // master model state
  bit          active = 0, never = 0, stale = 0;
  int          mcnt = 0, delay = 20;
  int          launch_cyc = 0, done_cyc = 0, wrt_cnt = 0;
  logic [15:0] key = '0, cur_cmd = '0;

  // requester state
  int rem0 = 0, rem1 = 0;
  bit hold0 = 0, drop0_pend = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic exp_t mk(input bit port, input logic [15:0] cmd, input logic [15:0] rdat,
                              input bit e, input bit tmo);
    exp_t x;
    x.port = port; x.cmd = cmd; x.rdat = rdat; x.err = e; x.tmo = tmo;
    return x;
  endfunction

  // One negedge: SPI master model, ack monitor, requester behaviour.
  task automatic step();
    exp_t e;
    int   lat;
    @(negedge clk);
    if (spi_wrt) begin
      wrt_cnt++;
      launch_cyc = cyc;
      cur_cmd    = spi_cmd;
      active     = 1;
      mcnt       = 0;
      if (sb.size() > 0) chk("spi_cmd_launch", 32'(spi_cmd), 32'(sb[0].cmd));
      if (!stale) spi_done = 1'b0;
    end else if (active) begin
      mcnt++;
      if (mcnt == 1) spi_done = 1'b0;
      if (!never && mcnt == delay) begin
        spi_done    = 1'b1;
        spi_rd_data = cur_cmd ^ key;
        done_cyc    = cyc;
        active      = 0;
      end
    end
    if (ack0 | ack1) begin
      if (sb.size() == 0) begin
        chk("unexpected_ack", 32'({ack1, ack0}), 32'd0);
      end else begin
        e = sb.pop_front();
        chk("ack_port", 32'({ack1, ack0}), e.port ? 32'd2 : 32'd1);
        chk("rdat", 32'(e.port ? rdat1 : rdat0), 32'(e.rdat));
        chk("err", 32'(err), 32'(e.err));
        chk("cmd_hold", 32'(spi_cmd), 32'(e.cmd));
        lat = e.tmo ? cyc - launch_cyc : cyc - done_cyc;
        chk(e.tmo ? "tmo_latency" : "done_latency", 32'(lat), e.tmo ? 32'd1024 : 32'd1);
      end
    end else if (err) begin
      chk("err_without_ack", 32'(err), 32'd0);
    end
    if (drop0_pend) begin
      req0 = 1'b0;
      drop0_pend = 0;
    end
    if (ack0 && rem0 > 0) begin
      rem0--;
      if (rem0 == 0) begin
        if (hold0) drop0_pend = 1;
        else req0 = 1'b0;
      end
    end
    if (ack1 && rem1 > 0) begin
      rem1--;
      if (rem1 == 0) req1 = 1'b0;
    end
  endtask

  task automatic wait_idle(input int maxc);
    int n = 0;
    do begin
      step();
      n++;
    end while (!(sb.size() == 0 && !busy && !req0 && !req1 && !drop0_pend) && n < maxc);
    if (n >= maxc) chk("wait_bound_expired", 32'd1, 32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req0 = 1'b0; req1 = 1'b0; rem0 = 0; rem1 = 0; drop0_pend = 0;
    active = 0; spi_done = 1'b0; never = 0; stale = 0;
    sb.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int w;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_spi_wrt", 32'(spi_wrt), 32'd0);
    chk("rst_spi_cmd", 32'(spi_cmd), 32'd0);
    chk("rst_acks", 32'({ack1, ack0}), 32'd0);
    chk("rst_rdat0", 32'(rdat0), 32'd0);
    chk("rst_rdat1", 32'(rdat1), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    rst_n = 1'b1;
    step();

    // single request on port 0, done 560 cycles after launch
    key = 16'hA55A ^ 16'h1234; delay = 560;
    w = wrt_cnt;
    sb.push_back(mk(0, 16'hA55A, 16'h1234, 0, 0));
    cmd0 = 16'hA55A; rem0 = 1; req0 = 1'b1;
    wait_idle(2000);
    chk("single_wrt_count", 32'(wrt_cnt - w), 32'd1);

    // tie from reset: 0 first, then strict alternation
    do_reset();
    key = 16'h0F0F; delay = 20;
    cmd0 = 16'h1111; cmd1 = 16'h2222;
    for (int i = 0; i < 4; i++)
      sb.push_back(mk(i[0], i[0] ? 16'h2222 : 16'h1111, (i[0] ? 16'h2222 : 16'h1111) ^ 16'h0F0F, 0, 0));
    rem0 = 2; rem1 = 2; req0 = 1'b1; req1 = 1'b1;
    wait_idle(1000);

    // stale done: still high at launch, dropped one cycle later, rises at 30
    chk("stale_done_pre", 32'(spi_done), 32'd1);
    stale = 1; delay = 30; cmd1 = 16'h3C3C;
    sb.push_back(mk(1, 16'h3C3C, 16'h3C3C ^ 16'h0F0F, 0, 0));
    rem1 = 1; req1 = 1'b1;
    wait_idle(500);
    stale = 0;

    // timeout on port 1, then a normal port 0 transfer
    never = 1; cmd1 = 16'hBEEF;
    sb.push_back(mk(1, 16'hBEEF, 16'hFFFF, 1, 1));
    rem1 = 1; req1 = 1'b1;
    wait_idle(3000);
    never = 0; delay = 15; cmd0 = 16'h0042;
    sb.push_back(mk(0, 16'h0042, 16'h0042 ^ 16'h0F0F, 0, 0));
    rem0 = 1; req0 = 1'b1;
    wait_idle(500);

    // requester holds req0 one extra cycle after ack: no second launch
    hold0 = 1; w = wrt_cnt; cmd0 = 16'h7777;
    sb.push_back(mk(0, 16'h7777, 16'h7777 ^ 16'h0F0F, 0, 0));
    rem0 = 1; req0 = 1'b1;
    wait_idle(500);
    repeat (5) step();
    chk("gap_wrt_count", 32'(wrt_cnt - w), 32'd1);
    chk("gap_busy", 32'(busy), 32'd0);
    hold0 = 0;

    // reset in WAIT after port 0 was last served; tie afterwards goes to 0
    never = 1; cmd0 = 16'h5555;
    sb.push_back(mk(0, 16'h5555, 16'hFFFF, 1, 1));
    rem0 = 1; req0 = 1'b1;
    repeat (20) step();
    chk("wait_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_spi_wrt", 32'(spi_wrt), 32'd0);
    chk("midrst_acks", 32'({ack1, ack0}), 32'd0);
    chk("midrst_rdat0", 32'(rdat0), 32'd0);
    chk("midrst_rdat1", 32'(rdat1), 32'd0);
    chk("midrst_err", 32'(err), 32'd0);
    req0 = 1'b0; rem0 = 0; sb.delete(); active = 0; spi_done = 1'b0; never = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    delay = 12; cmd0 = 16'hAAAA; cmd1 = 16'hBBBB;
    sb.push_back(mk(0, 16'hAAAA, 16'hAAAA ^ 16'h0F0F, 0, 0));
    sb.push_back(mk(1, 16'hBBBB, 16'hBBBB ^ 16'h0F0F, 0, 0));
    rem0 = 1; rem1 = 1; req0 = 1'b1; req1 = 1'b1;
    wait_idle(500);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
